// File: rtl/code_arbiter.sv
// code_arbiter
// Two-requester arbiter and burst sequencer in front of the shared 64-bit
// dual-output code unit. It is the only driver of that unit's Slt/En inputs.
//
// Build option: CODE_ARB_ROUND_ROBIN_EN
//   defined   - a tie goes to the requester that was not served last
//               (last-served resets to 1, so requester 0 wins the first tie)
//   undefined - fixed priority, requester 0 wins every tie
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_req0/i_req1    requests; held until o_done, or dropped by the owner to abort
//   i_len0/i_len1    burst length in En cycles, sampled at the grant decision
//   o_gnt0/o_gnt1    ownership flags (never both high)
//   o_slt            select to code unit (0 = requester 0, 1 = requester 1)
//   o_en             enable to code unit, high only in burst cycles
//   o_busy           high in any state other than IDLE
//   o_done           one-cycle completion pulse
//   o_remain         burst cycles still to issue
//
// state | meaning
// IDLE  | no owner, evaluate requests
// GRANT | owner latched, one setup cycle without En
// RUN   | En high, remaining count decrements
// DONE  | one-cycle completion pulse, then back to IDLE
module code_arbiter #(
  parameter int LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic [LEN_W-1:0] i_len0,
  input  logic [LEN_W-1:0] i_len1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_slt,
  output logic             o_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_remain
);

  localparam logic [LEN_W-1:0] ZERO = '0;
  localparam logic [LEN_W-1:0] ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic             r_owner;
  logic [LEN_W-1:0] r_remain;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_slt;
  logic             r_en;
  logic             r_busy;
  logic             r_done;

  logic w_any;
  logic w_win;
  logic w_owner_req;

  assign w_any       = i_req0 | i_req1;
  assign w_owner_req = r_owner ? i_req1 : i_req0;

`ifdef CODE_ARB_ROUND_ROBIN_EN
  logic r_last;
  // Tie goes to whoever was not served last; a lone request always wins.
  assign w_win = (i_req0 & i_req1) ? ~r_last : i_req1;
`else
  // Only meaningful when w_any is set: requester 0 has fixed priority.
  assign w_win = ~i_req0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_remain <= ZERO;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_slt    <= 1'b0;
      r_en     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef CODE_ARB_ROUND_ROBIN_EN
      r_last   <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state  <= S_GRANT;
            r_owner  <= w_win;
            r_remain <= w_win ? i_len1 : i_len0;
            r_gnt0   <= ~w_win;
            r_gnt1   <= w_win;
            r_slt    <= w_win;
            r_busy   <= 1'b1;
          end
        end
        S_GRANT: begin
          // A zero-length burst skips RUN and issues no En at all.
          if (r_remain != ZERO) begin
            r_state <= S_RUN;
            r_en    <= 1'b1;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_RUN: begin
          // Last cycle and owner abort both end the burst; when they
          // coincide it is a single normal completion.
          if (r_remain == ONE || !w_owner_req) begin
            r_state  <= S_DONE;
            r_en     <= 1'b0;
            r_done   <= 1'b1;
            r_remain <= ZERO;
          end else begin
            r_remain <= r_remain - ONE;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_done   <= 1'b0;
          r_gnt0   <= 1'b0;
          r_gnt1   <= 1'b0;
          r_busy   <= 1'b0;
          r_remain <= ZERO;
`ifdef CODE_ARB_ROUND_ROBIN_EN
          r_last   <= r_owner;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Slt is left untouched in IDLE so the code unit keeps its last selection.
  assign o_gnt0   = r_gnt0;
  assign o_gnt1   = r_gnt1;
  assign o_slt    = r_slt;
  assign o_en     = r_en;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_remain = r_remain;

endmodule

// File: doc/code_arbiter.md
# code_arbiter

Two-requester arbiter and sequencer for the shared 64-bit dual-output `code` unit. It grants one requester at a time and drives the unit's `Slt` and `En` inputs for a latched burst length. It signals completion with a one-cycle `Done` pulse. It sits directly in front of `code` and is the only driver of its `Slt` and `En` inputs.

## Interface
- `LEN_W`, default 4: width of the burst-length inputs and the internal down-counter.
- `Clk`  in  1: single clock, rising-edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `Req0`  in  1: requester 0 request; held high until `Done` or an intentional abort.
- `Req1`  in  1: requester 1 request; same rules as `Req0`.
- `Len0`  in  `LEN_W`: requester 0 burst length, in `En` cycles; sampled at grant decision.
- `Len1`  in  `LEN_W`: requester 1 burst length, in `En` cycles; sampled at grant decision.
- `Gnt0`  out  1: requester 0 owns the unit.
- `Gnt1`  out  1: requester 1 owns the unit.
- `Slt`  out  1: select to `code`; 0 = requester 0 / `Output0`, 1 = requester 1 / `Output1`.
- `En`  out  1: enable to `code`; high only during burst cycles.
- `Busy`  out  1: high in any state other than IDLE.
- `Done`  out  1: one-cycle completion pulse to the current owner.
- `Remain`  out  `LEN_W`: burst cycles still to issue.

## Operation
- All outputs are registered and are a function of state plus owner register. No combinational path from `Req*` to any output.
- States:
  - IDLE:
    - No request: stay in IDLE.
    - Any `Req` high: choose winner, latch owner and `Len<owner>` into `Remain`, go to GRANT.
  - GRANT, one cycle:
    - `Gnt<owner>`=1, `Slt`=owner, `En`=0.
    - Next state is RUN if `Remain`≠0, else DONE. A zero-length burst issues no `En`.
  - RUN:
    - `Gnt<owner>`=1, `Slt`=owner, `En`=1.
    - `Remain` decrements each cycle.
    - Go to DONE when `Remain`==1 at the edge.
    - Abort: owner's `Req` sampled low → DONE at the next edge; the remaining count is discarded.
  - DONE, one cycle:
    - `Done`=1, `Gnt<owner>`=1, `En`=0, `Slt`=owner.
    - Update last-served := owner, `Remain`:=0, go to IDLE.
- Winner selection:
  - Only one `Req` high: that requester wins.
  - Both `Req` high: the requester not last-served wins.
  - last-served resets to 1, so requester 0 wins the first tie.
- `Gnt0` and `Gnt1` are never high together. `Slt` holds its last value in IDLE.
- `Len*` and `Req*` changes by the owner after grant are ignored, except the `Req` drop that triggers an abort.
- Non-owner `Req` is held pending and is evaluated in the first IDLE cycle.

## Timing
- Reset low, at any time and in any state, takes effect immediately and asynchronously:
  - state=IDLE, last-served=1.
  - `Gnt0`=`Gnt1`=`Slt`=`En`=`Busy`=`Done`=0, `Remain`=0.
- Reset release: first decision at the first rising edge with `Reset` high.
- Latency:
  - `Req` high at edge k in IDLE → `Gnt` and `Busy` high after edge k.
  - First `En` cycle after edge k+1.
  - N = latched `Len`: `En` high for exactly N consecutive cycles, then `Done` for 1 cycle, then IDLE.
  - Total occupancy is N+2 cycles; N=0 gives 2 cycles (GRANT, DONE).
- Back-to-back: at least one IDLE cycle between one owner's `Done` and the next `Gnt`.
- Maximum burst is 2^`LEN_W`−1. No wrap: the counter never decrements below 1 in RUN.
- Simultaneous abort and last burst cycle (`Remain`==1, `Req` low): normal completion. `Done` pulses once.

## Configuration
- `CODE_ARB_ROUND_ROBIN_EN`:
  - Defined: the round-robin tie-break described above.
  - Undefined: fixed priority; requester 0 always wins when both `Req` are high. The last-served register is not built, and `Done` and `Remain` behaviour are unchanged.

## Test plan
- Reset: assert `Reset`=0 mid-RUN with `Remain`=3 → all outputs 0 within the same cycle. After release with `Req0`=1 and `Len0`=4 → `Gnt0` after 1 edge, `En` high 4 cycles, `Done` 1 cycle.
- Single request: `Req1`=1, `Len1`=2 → `Slt`=1 from GRANT onward, `En` high 2 cycles, `Remain` 2→1→0, `Busy` high 4 cycles.
- Tie, round-robin: `Req0`=`Req1`=1 held, `Len`=1 each → grant order 0,1,0,1 with one IDLE gap between grants. With the macro undefined → always 0.
- Zero length: `Req0`=1, `Len0`=0 → GRANT then DONE, `En` never high, `Done` pulse 2 cycles after the request edge.
- Abort: `Req0` dropped after 2 of 5 `En` cycles → `En` low the next cycle, `Done`=1, `Remain`=0. A pending `Req1` is granted after one IDLE cycle.
- Mutual exclusion: random `Req`/`Len` for 10k cycles → never both `Gnt` high. `En` is high only in RUN, and the count of `En` cycles per grant is ≤ latched `Len`.
